// File: rtl/fadd_share_arbiter_pkg.sv
// fadd_share_pkg: shared defaults, tag type and FP constants for the AddFloat share arbiter.
package fadd_share_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int LATENCY_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int IDX_W = 3;
    typedef struct packed {
        logic valid;
        logic [IDX_W-1:0] idx;
    } tag_t;
    localparam logic [31:0] FP_ONE = 32'h3f800000;
    localparam logic [31:0] FP_1P3 = 32'h3fa66666;
    localparam logic [31:0] FP_2P3 = 32'h40133333;
endpackage

// File: rtl/fadd_share_arbiter_if.sv
// fadd_share_arbiter_if: requester-side request/operand/grant/result bundle.
interface fadd_share_arbiter_if
    import fadd_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic [NUM_REQ-1:0] i_req;
    logic [NUM_REQ*DATA_W-1:0] i_op_a;
    logic [NUM_REQ*DATA_W-1:0] i_op_b;
    logic [NUM_REQ-1:0] o_grant;
    logic [DATA_W-1:0] o_result;
    logic [NUM_REQ-1:0] o_result_valid;
    modport master (output i_req, i_op_a, i_op_b, input o_grant, o_result, o_result_valid);
    modport slave (input i_req, i_op_a, i_op_b, output o_grant, o_result, o_result_valid);
endinterface

// File: rtl/fadd_share_arbiter_rr_picker.sv
// fadd_rr_picker: round-robin pointer plus wrap-around first-eligible search.
module fadd_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW = $clog2(NUM_REQ)
) (
    input logic clock,
    input logic reset,
    input logic ce,
    input logic [NUM_REQ-1:0] eligible,
    output logic [IW-1:0] win,
    output logic found
);
    logic [IW-1:0] ptr;
    logic [2*NUM_REQ-1:0] dbl;
    logic [IW:0] off;
    logic [IW:0] sum;
    assign dbl = {eligible, eligible} >> ptr;
    // dbl[i] is requester ptr+i; scanning downward leaves the closest one in off
    always_comb begin
        found = 1'b0;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                off = (IW+1)'(i);
            end
        end
        sum = {1'b0, ptr} + off;
        win = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr <= '0;
        else if (ce && found) ptr <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
    end
endmodule

// File: rtl/fadd_share_arbiter.sv
// fadd_share_arbiter: round-robin sharing of one pipelined AddFloat core with tag-routed results.
// Define FADD_SHARE_ARBITER_STATS_EN to enable the o_issue_count grant counter.
module fadd_share_arbiter
    import fadd_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic clock,
    input logic reset,
    input logic ce,
    fadd_share_arbiter_if.slave bus,
    output logic [DATA_W-1:0] o_fadd_a,
    output logic [DATA_W-1:0] o_fadd_b,
    input logic [DATA_W-1:0] i_fadd_result,
    output logic o_busy,
    output logic [31:0] o_issue_count
);
    localparam int IW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] eligible;
    logic [IW-1:0] win;
    logic found;
    logic any_tag;
    tag_t pipe [LATENCY+1];
    // a requester already holding a grant is masked so a late-dropping i_req is not reissued
    assign eligible = bus.i_req & ~bus.o_grant;
    fadd_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .clock(clock),
        .reset(reset),
        .ce(ce),
        .eligible(eligible),
        .win(win),
        .found(found)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.o_grant <= '0;
            bus.o_result <= '0;
            bus.o_result_valid <= '0;
            o_fadd_a <= '0;
            o_fadd_b <= '0;
            for (int i = 0; i <= LATENCY; i++) pipe[i] <= '0;
        end else if (ce) begin
            bus.o_grant <= found ? NUM_REQ'(1) << win : '0;
            if (found) begin
                o_fadd_a <= bus.i_op_a[win*DATA_W +: DATA_W];
                o_fadd_b <= bus.i_op_b[win*DATA_W +: DATA_W];
            end
            pipe[0] <= {found, IDX_W'(win)};
            for (int i = 1; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
            // stage LATENCY lines up with the core output for the op issued LATENCY edges ago
            bus.o_result_valid <= pipe[LATENCY].valid ? NUM_REQ'(1) << pipe[LATENCY].idx : '0;
            if (pipe[LATENCY].valid) bus.o_result <= i_fadd_result;
        end
    end
    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i <= LATENCY; i++) any_tag = any_tag | pipe[i].valid;
    end
    assign o_busy = |bus.o_grant | any_tag;
`ifdef FADD_SHARE_ARBITER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) o_issue_count <= '0;
        else if (ce && found) o_issue_count <= o_issue_count + 1'b1;
    end
`else
    assign o_issue_count = 32'h0;
`endif
endmodule

// File: doc/fadd_share_arbiter.md
Name: fadd_share_arbiter

Overview:
- Shares one pipelined single-precision AddFloat core (fixed latency, no backpressure) among NUM_REQ requesters.
- Uses round-robin arbitration and issues at most one add per ce cycle.
- Tracks the owner of each in-flight operation in a tag pipeline and routes each result back to its owner as a one-cycle valid pulse.
- Sits between the generated method FSMs and the single AddFloat instance, replacing per-method adder instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LATENCY, 5, AddFloat latency in ce-enabled cycles (1..16)
- DATA_W, 32, operand/result width (IEEE-754 single)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; all state advances only when high
- i_req  in  NUM_REQ  per-requester add request, level
- i_op_a  in  NUM_REQ*DATA_W  operand A, requester k at bits [k*DATA_W +: DATA_W]
- i_op_b  in  NUM_REQ*DATA_W  operand B, same packing
- o_grant  out  NUM_REQ  one-hot, one-cycle grant pulse (registered)
- o_fadd_a  out  DATA_W  registered operand A to AddFloat
- o_fadd_b  out  DATA_W  registered operand B to AddFloat
- i_fadd_result  in  DATA_W  AddFloat result
- o_result  out  DATA_W  registered result, shared bus
- o_result_valid  out  NUM_REQ  one-hot result strobe
- o_busy  out  1  high while any grant or operation is in flight
- o_issue_count  out  32  grant counter (see Optional Feature)

Behaviour:
- Reset values: o_grant=0, o_fadd_a=0, o_fadd_b=0, o_result=0, o_result_valid=0, o_busy=0, o_issue_count=0, RR pointer=0, all tag valids=0.
- ce low: every register holds, including pulses. A pulse therefore stays visible until the next ce-high edge. Latency is counted in ce-high edges only.
- Arbitration at each ce-high edge:
  - Eligible set = i_req & ~o_grant. A requester whose grant is currently high is masked, so a requester that holds i_req for one extra cycle is not issued twice.
  - Winner = first eligible index at or after ptr, searching upward and wrapping at NUM_REQ-1 to 0.
  - On a win: o_grant=onehot(winner), o_fadd_a/b=winner's operands, ptr=winner+1 mod NUM_REQ, tag {valid=1, idx=winner} pushed into the tag pipe.
  - With no winner: o_grant=0, o_fadd_a/b hold, tag {valid=0} pushed, ptr holds.
- Requester contract:
  - Hold i_req and operands stable until o_grant[k] is seen.
  - Deassert i_req in the grant cycle, or keep it high to request again; the request is eligible again on the following edge.
- Timing: request sampled at edge k → o_grant and o_fadd_a/b valid after k → AddFloat result valid after k+LATENCY → o_result/o_result_valid valid after k+LATENCY+1. Total request-to-result latency is LATENCY+1 ce cycles.
- Tag pipe: LATENCY+1 stages of {valid, idx[$clog2(NUM_REQ)-1:0]}, shifted every ce-high edge.
  - Exit stage valid: o_result_valid=onehot(idx) and o_result=i_fadd_result.
  - Exit stage invalid: o_result_valid=0 and o_result holds.
- Throughput is 1 add/cycle. Results return in issue order. Back-to-back results on different requesters are allowed.
- o_busy = |o_grant | any tag valid.
- Reset mid-operation: in-flight tags are discarded asynchronously. No o_result_valid may appear for pre-reset issues, even if the AddFloat core still drains. After release, ptr=0, so requester 0 has top priority.

Optional Feature:
- Macro FADD_SHARE_ARBITER_STATS_EN.
- Defined: o_issue_count increments by 1 on every ce-high edge that issues a grant, wraps at 2^32, and resets to 0.
- Undefined: o_issue_count is tied to 32'h0 and no counter logic exists. The port list is unchanged.

Decomposition:
- Package fadd_share_pkg holds:
  - default NUM_REQ/LATENCY/DATA_W
  - tag struct typedef {valid, idx}
  - FP constants used by benches: ONE=32'h3f800000, 1.3=32'h3fa66666, 2.3=32'h40133333.
- One sub-module, fadd_rr_picker: the pointer register plus masked wrap-around priority search, producing winner index and found flag. The tag pipe and output registers stay in the top.

Test Plan:
- Single issue: LATENCY=5; req0 with a=32'h3f800000, b=32'h3fa66666 → o_grant=4'b0001 after edge k; o_fadd_a/b match the operands; with the bench model adder, o_result=32'h40133333 and o_result_valid=4'b0001 for exactly one cycle after edge k+6; o_busy falls after it.
- Full contention: all four requesters re-request every cycle → grants 0,1,2,3,0,1,... one per cycle with no gaps; results return in the same order, each tagged to the correct requester, 6 cycles after its grant.
- Wrap/skip: only req1 and req3 active, ptr at 2 → grant 3, then 1, then 3; never 0 or 2.
- ce stall: ce low for 3 cycles with 3 ops in flight → all outputs frozen; results appear 3 clock cycles late, and no pulse is lost or duplicated.
- Reset mid-flight: assert reset with 3 ops in flight → all outputs 0 immediately, without waiting for a clock edge; after release, no o_result_valid for 10 cycles; a simultaneous req0/req2 → grant 0 first.
- Stats: 10 grants issued → o_issue_count=10 with FADD_SHARE_ARBITER_STATS_EN defined, and 0 without it.
